gate_sweeper: RTL and testbench
===============================

Name: gate_sweeper

Overview:
- Test-harness stage that wraps any 3-input truth-table gate module (in1, in2, in3 -> out).
- Upstream role: drives the gate's inputs through all 8 combinations in order.
- Downstream role: samples the gate's out after a settle interval and assembles the 8-bit truth-table word.
- Compares the assembled word against an expected code, so on-chip or bench checks confirm each gate matches its hex name.

Parameters:
SETTLE_CYCLES, 4, clocks each input row is held before out is sampled; legal range 1..255
CNT_W, 8, width of the settle counter; must hold SETTLE_CYCLES-1

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a sweep; honoured only in IDLE
abort  input  1  cancel a sweep in progress
expected  input  8  expected truth-table code; captured on accepted start
gate_out  input  1  out of the gate under test
in1  output  1  gate input, MSB of the row index
in2  output  1  gate input, middle bit of the row index
in3  output  1  gate input, LSB of the row index
busy  output  1  high while sweeping
done  output  1  one-cycle pulse when a sweep completes
table_code  output  8  assembled truth table; bit (7-row) = out for row {in1,in2,in3}
match  output  1  table_code == captured expected; valid from done, held
first_err_row  output  3  lowest row index that mismatched; 0 when match

Behaviour:
- Reset (async, rst_n low): all outputs 0; FSM = IDLE; internal row, counter, shadow table and captured expected cleared.
- FSM states and transitions:
  - IDLE -> RUN: on start & !abort. At that edge: row = 0, cnt = 0, expected captured.
  - RUN, each edge:
    - If abort: -> IDLE, row = 0. No done; table_code, match and first_err_row unchanged.
    - Else if cnt == SETTLE_CYCLES-1: capture gate_out into shadow bit (7-row); cnt = 0. If row == 7 -> DONE, else row + 1.
    - Else: cnt + 1.
  - DONE: done = 1 for exactly this cycle. table_code, match and first_err_row are already updated, with the row-7 sample included. Next edge -> IDLE.
- Output timing:
  - {in1,in2,in3} = row while in RUN; 000 in IDLE and DONE.
  - busy = 1 in RUN only.
- Latency: each row is held for SETTLE_CYCLES clocks. done is high in the cycle after edge E0 + 8*SETTLE_CYCLES, where E0 is the start-accept edge. Total sweep is 8*SETTLE_CYCLES + 1 cycles, start edge to done cycle.
- Bit ordering: row 000 maps to MSB and row 111 to LSB, so the code equals the gate's hex name.
- first_err_row: lowest row r where shadow bit (7-r) != expected bit (7-r), computed combinationally from the shadow and registered at the DONE transition.
- Boundary rules:
  - start while busy or in DONE: ignored; expected not re-captured.
  - start & abort in the same IDLE cycle: abort wins, stay IDLE.
  - abort in IDLE or DONE: no effect; done still pulses if in DONE.
  - Back-to-back sweeps: start asserted during the done cycle is ignored; the earliest accepted start is the first IDLE cycle.
  - rst_n low mid-sweep: immediate return to reset values, gate inputs forced to 000 asynchronously.
- gate_out is assumed synchronous to clk or settled within SETTLE_CYCLES; no synchronizer in this block.

Test Plan:
- Normal sweep: SETTLE_CYCLES=4, gate model with out=1 for rows 010 and 111, expected=0x21, start pulse -> rows 0..7 each held 4 clocks; done 33 cycles after start edge; table_code=0x21, match=1, first_err_row=0.
- Mismatch detection: same gate, expected=0x22 -> table_code=0x21, match=0, first_err_row=6.
- Abort mid-sweep: abort asserted during row 3 -> next cycle busy=0, inputs=000, no done pulse; table_code/match keep previous sweep's values (0x21/1).
- Reset mid-sweep: rst_n low during row 5 -> in1..in3, busy, done, table_code, match all 0 immediately, before the next clk edge; after release a fresh sweep completes normally.
- Start robustness: start held high continuously -> sweeps repeat with one IDLE cycle between done and the next row 0; start pulses during RUN do not restart the row sequence.
- Minimum settle: SETTLE_CYCLES=1, constant-1 gate -> done 9 cycles after start, table_code=0xFF; constant-0 gate with expected=0xFF -> match=0, first_err_row=0.

Source files
------------

// File: rtl/gate_sweeper.sv
// Sweeps a 3-input gate through rows 000..111, samples its output after a settle
// interval, and compares the assembled truth-table word against an expected code.
module gate_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] expected,
  input  logic       gate_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_code,
  output logic       match,
  output logic [2:0] first_err_row
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [2:0]       row, row_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [7:0]       shadow, shadow_d;
  logic [7:0]       exp_q, exp_d;
  logic [7:0]       code_d;
  logic             match_d;
  logic [2:0]       err_d;
  logic [2:0]       gin_d;
  logic             busy_d;
  logic             done_d;
  logic [7:0]       shadow_smp;
  logic [7:0]       diff;
  logic [2:0]       err_row;

  // Shadow word with the current row's sample merged in; row 0 lands in the MSB.
  always_comb begin
    shadow_smp = shadow;
    shadow_smp[3'(3'd7 - row)] = gate_out;
  end

  // Lowest mismatching row index; scanning downward lets the lowest row win.
  always_comb begin
    diff    = shadow_smp ^ exp_q;
    err_row = 3'd0;
    for (int r = 7; r >= 0; r--) begin
      if (diff[7-r]) err_row = 3'(r);
    end
  end

  always_comb begin
    state_d  = state;
    row_d    = row;
    cnt_d    = cnt;
    shadow_d = shadow;
    exp_d    = exp_q;
    code_d   = table_code;
    match_d  = match;
    err_d    = first_err_row;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_d = RUN;
          row_d   = 3'd0;
          cnt_d   = '0;
          exp_d   = expected;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          row_d   = 3'd0;
          cnt_d   = '0;
        end else if (cnt == CNT_LAST) begin
          shadow_d = shadow_smp;
          cnt_d    = '0;
          if (row == 3'd7) begin
            state_d = DONE;
            row_d   = 3'd0;
            code_d  = shadow_smp;
            match_d = (shadow_smp == exp_q);
            err_d   = err_row;
          end else begin
            row_d = row + 3'd1;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
    gin_d  = (state_d == RUN) ? row_d : 3'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      row           <= 3'd0;
      cnt           <= '0;
      shadow        <= 8'd0;
      exp_q         <= 8'd0;
      table_code    <= 8'd0;
      match         <= 1'b0;
      first_err_row <= 3'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      {in1, in2, in3} <= 3'd0;
    end else begin
      state         <= state_d;
      row           <= row_d;
      cnt           <= cnt_d;
      shadow        <= shadow_d;
      exp_q         <= exp_d;
      table_code    <= code_d;
      match         <= match_d;
      first_err_row <= err_d;
      busy          <= busy_d;
      done          <= done_d;
      {in1, in2, in3} <= gin_d;
    end
  end

endmodule

// File: tb/tb_gate_sweeper.sv
// Directed bench for gate_sweeper: one instance with 4-cycle settle, one with 1-cycle settle,
// each wrapping a behavioural gate defined by a truth-table word.
module tb_gate_sweeper;

  logic clk;
  logic rst_n;

  logic       start0, abort0, gout0;
  logic [7:0] exp0, tt0;
  logic       a1, a2, a3, busy0, done0, match0;
  logic [7:0] code0;
  logic [2:0] err0, idx0;

  logic       start1, abort1, gout1;
  logic [7:0] exp1, tt1;
  logic       b1, b2, b3, busy1, done1, match1;
  logic [7:0] code1;
  logic [2:0] err1, idx1;

  int n_checks;
  int n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural gates: row {in1,in2,in3} reads bit (7-row) of the truth word.
  assign idx0  = 3'd7 - {a1, a2, a3};
  assign gout0 = tt0[idx0];
  assign idx1  = 3'd7 - {b1, b2, b3};
  assign gout1 = tt1[idx1];

  gate_sweeper #(.SETTLE_CYCLES(4), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .expected(exp0),
    .gate_out(gout0), .in1(a1), .in2(a2), .in3(a3), .busy(busy0), .done(done0),
    .table_code(code0), .match(match0), .first_err_row(err0)
  );

  gate_sweeper #(.SETTLE_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .expected(exp1),
    .gate_out(gout1), .in1(b1), .in2(b2), .in3(b3), .busy(busy1), .done(done1),
    .table_code(code1), .match(match1), .first_err_row(err1)
  );

  // Runs one sweep on dut0; lat = negedges from start to done (-1 on timeout).
  task automatic sweep0(input logic [7:0] e, input bit hold, input int poke_at,
                        output int lat, output bit rows_ok);
    lat = 0;
    rows_ok = 1'b1;
    @(negedge clk);
    start0 = 1'b1;
    exp0   = e;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      start0 = hold || (lat == poke_at);
      if (lat == poke_at) exp0 = ~e;
      if (lat <= 32) begin
        if ({a1, a2, a3} !== 3'((lat - 1) / 4) || busy0 !== 1'b1) rows_ok = 1'b0;
      end
      if (done0 === 1'b1) break;
    end
    if (done0 !== 1'b1) lat = -1;
  endtask

  task automatic sweep1(input logic [7:0] e, output int lat);
    lat = 0;
    @(negedge clk);
    start1 = 1'b1;
    exp1   = e;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      start1 = 1'b0;
      if (done1 === 1'b1) break;
    end
    if (done1 !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({a1, a2, a3, busy0, done0, code0, match0, err0} !== 17'd0)
      $display("FAIL reset_dut0 got %h want 0", {a1, a2, a3, busy0, done0, code0, match0, err0});
    else n_pass++;
    n_checks++;
    if ({b1, b2, b3, busy1, done1, code1, match1, err1} !== 17'd0)
      $display("FAIL reset_dut1 got %h want 0", {b1, b2, b3, busy1, done1, code1, match1, err1});
    else n_pass++;
  endtask

  task automatic test_normal();
    int lat;
    bit ok;
    tt0 = 8'h21;
    sweep0(8'h21, 1'b0, -1, lat, ok);
    n_checks++;
    if (lat !== 33) $display("FAIL normal_latency got %0d want 33", lat); else n_pass++;
    n_checks++;
    if (ok !== 1'b1) $display("FAIL normal_rows got %0b want 1", ok); else n_pass++;
    n_checks++;
    if (code0 !== 8'h21) $display("FAIL normal_code got %h want 21", code0); else n_pass++;
    n_checks++;
    if (match0 !== 1'b1 || err0 !== 3'd0)
      $display("FAIL normal_match got %b/%0d want 1/0", match0, err0);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({done0, busy0, a1, a2, a3} !== 5'd0)
      $display("FAIL done_one_cycle got %b want 00000", {done0, busy0, a1, a2, a3});
    else n_pass++;
  endtask

  task automatic test_abort();
    int n;
    bit saw_done;
    @(negedge clk);
    start0 = 1'b1;
    exp0   = 8'h00;
    @(negedge clk);
    start0 = 1'b0;
    n = 0;
    while ({a1, a2, a3} !== 3'd3 && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if ({a1, a2, a3} !== 3'd3) $display("FAIL abort_reach_row3 got %0d want 3", {a1, a2, a3});
    else n_pass++;
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    n_checks++;
    if ({busy0, a1, a2, a3, done0} !== 5'd0)
      $display("FAIL abort_idle got %b want 00000", {busy0, a1, a2, a3, done0});
    else n_pass++;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done0 === 1'b1 || busy0 === 1'b1) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0) $display("FAIL abort_no_done got %b want 0", saw_done); else n_pass++;
    n_checks++;
    if (code0 !== 8'h21 || match0 !== 1'b1)
      $display("FAIL abort_keep got %h/%b want 21/1", code0, match0);
    else n_pass++;
  endtask

  task automatic test_mismatch();
    int lat;
    bit ok;
    tt0 = 8'h21;
    sweep0(8'h22, 1'b0, -1, lat, ok);
    n_checks++;
    if (lat !== 33) $display("FAIL mismatch_latency got %0d want 33", lat); else n_pass++;
    n_checks++;
    if (code0 !== 8'h21) $display("FAIL mismatch_code got %h want 21", code0); else n_pass++;
    n_checks++;
    if (match0 !== 1'b0) $display("FAIL mismatch_match got %b want 0", match0); else n_pass++;
    n_checks++;
    if (err0 !== 3'd6) $display("FAIL mismatch_err_row got %0d want 6", err0); else n_pass++;
  endtask

  task automatic test_start_ignored();
    int lat;
    bit ok;
    tt0 = 8'h21;
    sweep0(8'h21, 1'b0, 10, lat, ok);
    n_checks++;
    if (lat !== 33 || ok !== 1'b1)
      $display("FAIL start_in_run got lat=%0d rows=%0b want 33/1", lat, ok);
    else n_pass++;
    n_checks++;
    if (match0 !== 1'b1) $display("FAIL start_no_recapture got %b want 1", match0); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_start_abort();
    @(negedge clk);
    start0 = 1'b1;
    abort0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    abort0 = 1'b0;
    n_checks++;
    if ({busy0, a1, a2, a3} !== 4'd0)
      $display("FAIL start_abort_same got %b want 0000", {busy0, a1, a2, a3});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat;
    int n;
    bit ok;
    tt0 = 8'h21;
    sweep0(8'h21, 1'b1, -1, lat, ok);
    n_checks++;
    if (lat !== 33) $display("FAIL b2b_first_latency got %0d want 33", lat); else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({busy0, done0} !== 2'b00) $display("FAIL b2b_idle_gap got %b want 00", {busy0, done0});
    else n_pass++;
    @(negedge clk);
    start0 = 1'b0;
    n_checks++;
    if ({busy0, a1, a2, a3} !== 4'b1000)
      $display("FAIL b2b_restart got %b want 1000", {busy0, a1, a2, a3});
    else n_pass++;
    n = 1;
    while (done0 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n !== 33 || match0 !== 1'b1)
      $display("FAIL b2b_second got lat=%0d match=%b want 33/1", n, match0);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n;
    int lat;
    bit ok;
    @(negedge clk);
    start0 = 1'b1;
    exp0   = 8'h21;
    @(negedge clk);
    start0 = 1'b0;
    n = 0;
    while ({a1, a2, a3} !== 3'd5 && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if ({a1, a2, a3} !== 3'd5) $display("FAIL reset_reach_row5 got %0d want 5", {a1, a2, a3});
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a1, a2, a3, busy0, done0, code0, match0} !== 14'd0)
      $display("FAIL reset_mid_async got %h want 0", {a1, a2, a3, busy0, done0, code0, match0});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    sweep0(8'h21, 1'b0, -1, lat, ok);
    n_checks++;
    if (lat !== 33 || ok !== 1'b1 || code0 !== 8'h21 || match0 !== 1'b1)
      $display("FAIL reset_then_sweep got lat=%0d rows=%0b code=%h match=%b want 33/1/21/1",
               lat, ok, code0, match0);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_min_settle();
    int lat;
    tt1 = 8'hFF;
    sweep1(8'hFF, lat);
    n_checks++;
    if (lat !== 9) $display("FAIL min_latency got %0d want 9", lat); else n_pass++;
    n_checks++;
    if (code1 !== 8'hFF || match1 !== 1'b1)
      $display("FAIL min_ones got %h/%b want ff/1", code1, match1);
    else n_pass++;
    @(negedge clk);
    tt1 = 8'h00;
    sweep1(8'hFF, lat);
    n_checks++;
    if (code1 !== 8'h00 || match1 !== 1'b0 || err1 !== 3'd0)
      $display("FAIL min_zeros got %h/%b/%0d want 00/0/0", code1, match1, err1);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n  = 1'b0;
    start0 = 1'b0; abort0 = 1'b0; exp0 = 8'h00; tt0 = 8'h21;
    start1 = 1'b0; abort1 = 1'b0; exp1 = 8'h00; tt1 = 8'hFF;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_normal();
    test_abort();
    test_mismatch();
    test_start_ignored();
    test_start_abort();
    test_back_to_back();
    test_reset_mid();
    test_min_settle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
